// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, FSM states and lane/extension helpers for the memory stage.
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_BYTE ? 4'b0001 << a : sz == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction

  // Stores replicate the datum across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    return sz == SZ_BYTE ? {4{d[7:0]}} : sz == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    return sz == SZ_BYTE ? {{24{b[7] & ~uns}}, b} :
           sz == SZ_HALF ? {{16{h[15] & ~uns}}, h} : w;
  endfunction
endpackage

// File: rtl/mem_wb_stage_dmem_be.sv
// dmem_be: word-wide data memory with per-byte write enables and a combinational read port.
module dmem_be #(
  parameter int MEM_WORDS = 256,
  parameter int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [MEM_WORDS];

  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: sub-word load/store memory stage with wait states, misalignment bubbles
// and the MEM/WB pipeline register.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter int MEM_WORDS = 256,
  parameter int MEM_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic              mem_write_m,
  input  logic [1:0]        size_m,
  input  logic              unsigned_m,
  input  logic [REG_W-1:0]  write_reg_m,
  input  logic [DATA_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] write_data_m,
  output logic              stall_o,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic              misalign_w,
  output logic [REG_W-1:0]  write_reg_w,
  output logic [DATA_W-1:0] alu_out_w,
  output logic [DATA_W-1:0] read_data_w
);
  localparam int AW = $clog2(MEM_WORDS);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            w_mem_op, w_misalign, w_wait_req;
  logic [3:0]      w_we;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_unused   = &{1'b0, alu_out_m[DATA_W-1:AW+2]};
  assign w_mem_op   = valid_m & (mem_to_reg_m | mem_write_m);
  assign w_misalign = w_mem_op & ((size_m == SZ_HALF & alu_out_m[0]) |
                                  (size_m[1] & alu_out_m[1:0] != 2'b00));
  assign w_wait_req = w_mem_op & ~w_misalign & (MEM_LATENCY != 0);
  // Gating with rst_n makes stall and writes drop the moment reset asserts.
  assign stall_o    = rst_n & (r_state == S_IDLE ? w_wait_req : r_cnt > 4'd1);
  assign w_we       = (rst_n & valid_m & mem_write_m & ~w_misalign & ~stall_o) ?
                      lane_mask(size_m, alu_out_m[1:0]) : 4'b0000;

  dmem_be #(.MEM_WORDS(MEM_WORDS)) u_dmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (alu_out_m[AW+1:2]),
    .i_wdata (store_data(size_m, write_data_m)),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_wait_req) begin
        r_state <= S_WAIT;
        r_cnt   <= 4'(MEM_LATENCY);
      end
    end else begin
      r_cnt   <= r_cnt - 4'd1;
      r_state <= r_cnt == 4'd1 ? S_IDLE : S_WAIT;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      misalign_w   <= 1'b0;
      write_reg_w  <= '0;
      alu_out_w    <= '0;
      read_data_w  <= '0;
    end else if (stall_o) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      misalign_w   <= 1'b0;
    end else begin
      valid_w      <= valid_m;
      reg_write_w  <= valid_m & reg_write_m & ~w_misalign;
      mem_to_reg_w <= mem_to_reg_m;
      misalign_w   <= w_misalign;
      write_reg_w  <= write_reg_m;
      alu_out_w    <= alu_out_m;
      read_data_w  <= load_ext(w_rdata, size_m, alu_out_m[1:0], unsigned_m);
    end
endmodule
